// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared constants and state encodings for the instruction-memory
// loader and its UART receiver.
//
// Contents:
//   INSTR_W      instruction word width (15 bits)
//   IMEM_ADDR_W  instruction memory address width (8 bits, 256 words)
//   LOADER_SYNC  frame sync byte (0xA5)
//   loader_state_e  frame FSM states; S_CSUM exists only when
//                   IMEM_LOADER_CSUM_EN is defined
//   rx_state_e      UART receiver states
//
// Build option: IMEM_LOADER_CSUM_EN adds the checksum byte and CSUM state.
package cpu_pkg;

  localparam int INSTR_W     = 15;
  localparam int IMEM_ADDR_W = 8;
  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_WHI   = 3'd2,
`ifdef IMEM_LOADER_CSUM_EN
    S_WLO   = 3'd3,
    S_CSUM  = 3'd4
`else
    S_WLO   = 3'd3
`endif
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART byte receiver, LSB first, idle-high line.
//
// The raw line goes through a two-flop synchronizer (reset to 1 = idle)
// before anything looks at it. A falling edge on the synchronized line starts
// a frame; the start bit is re-checked at half a bit time so that short low
// glitches fall back to idle silently. Data bits and the stop bit are then
// sampled every CLKS_PER_BIT cycles, i.e. at the middle of each bit.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   rx           raw serial input (asynchronous to clk)
//   rx_data      last received byte, valid while rx_valid is high
//   rx_valid     one-cycle pulse: a byte with a good stop bit arrived
//   rx_err       one-cycle pulse: stop bit sampled low (byte discarded)
//   dbg_state    current receiver state
//
// Parameter CLKS_PER_BIT must be at least 2.
module uart_rx
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output rx_state_e  dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  rx_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign dbg_state = state;

  // Synchronizer plus one extra stage for falling-edge detection. All three
  // reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s2) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: glitch, not a start.
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads instruction memory from a UART frame while holding the
// CPU in reset.
//
// Frame: 0xA5, N (0 = 256), N words sent high byte then low byte, and, when
// IMEM_LOADER_CSUM_EN is defined, a trailing XOR checksum over all word bytes.
// High bytes must have bit 7 clear; bits 6:0 become wdata[14:8].
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   rx            UART serial input, 8N1, idle high
//   cpu_hold      high from sync-byte acceptance until the FSM is back in IDLE
//   imem_we       one-cycle write strobe, one cycle after the low byte
//   imem_addr     write address, stable during imem_we
//   imem_wdata    instruction word being written
//   done          one-cycle pulse on successful frame completion
//   err           sticky error; cleared by reset or a new sync byte
//   dbg_state     frame FSM state
//   dbg_rx_state  UART receiver state
//
// Build option: IMEM_LOADER_CSUM_EN. Without it there is no CSUM state and
// done pulses the cycle after the final write.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic                   cpu_hold,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [INSTR_W-1:0]     imem_wdata,
  output logic                   done,
  output logic                   err,
  output loader_state_e          dbg_state,
  output rx_state_e              dbg_rx_state
);

  // Words-remaining counter needs one extra bit so N=0 can mean 256.
  localparam int WCNT_W = IMEM_ADDR_W + 1;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_err;
  loader_state_e     state;
  logic [6:0]        hi_r;
  logic [WCNT_W-1:0] words_left;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign dbg_state = state;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .dbg_state (dbg_rx_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cpu_hold   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      hi_r       <= '0;
      words_left <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;

      // The write cycle itself: the address is bumped only afterwards so it
      // stays stable while imem_we is high, and never past the last word so
      // a 256-word frame does not wrap back to 0.
      if (imem_we) begin
        if (words_left != '0) begin
          imem_addr <= imem_addr + IMEM_ADDR_W'(1);
        end
`ifndef IMEM_LOADER_CSUM_EN
        else begin
          done     <= 1'b1;
          state    <= S_IDLE;
          cpu_hold <= 1'b0;
        end
`endif
      end

      if (rx_err) begin
        // Framing error: the byte is lost, so whatever frame was running
        // cannot be trusted any more.
        err      <= 1'b1;
        state    <= S_IDLE;
        cpu_hold <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_byte == LOADER_SYNC) begin
              state    <= S_COUNT;
              cpu_hold <= 1'b1;
              err      <= 1'b0;
            end
          end
          S_COUNT: begin
            words_left <= (rx_byte == 8'h00) ? WCNT_W'(1 << IMEM_ADDR_W)
                                             : WCNT_W'(rx_byte);
            imem_addr  <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= '0;
`endif
            state      <= S_WHI;
          end
          S_WHI: begin
            if (rx_byte[7]) begin
              err      <= 1'b1;
              state    <= S_IDLE;
              cpu_hold <= 1'b0;
            end else begin
              hi_r  <= rx_byte[6:0];
`ifdef IMEM_LOADER_CSUM_EN
              csum  <= csum ^ rx_byte;
`endif
              state <= S_WLO;
            end
          end
          S_WLO: begin
            imem_wdata <= {hi_r, rx_byte};
            imem_we    <= 1'b1;
            words_left <= words_left - WCNT_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= csum ^ rx_byte;
            state      <= (words_left == WCNT_W'(1)) ? S_CSUM : S_WHI;
`else
            // On the last word stay here; the write cycle above finishes
            // the frame one cycle later.
            if (words_left != WCNT_W'(1)) state <= S_WHI;
`endif
          end
`ifdef IMEM_LOADER_CSUM_EN
          S_CSUM: begin
            if (rx_byte == csum) done <= 1'b1;
            else                 err  <= 1'b1;
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end
`endif
          default: begin
            state    <= S_IDLE;
            cpu_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- directed self-checking bench for imem_loader.
// Writes are checked against an expected queue of {addr, wdata}; frame-level
// results (done/err/cpu_hold/state) are checked after each directed step.
// Expectations that differ with IMEM_LOADER_CSUM_EN are selected by the same
// macro.
module tb_imem_loader;
  import cpu_pkg::*;

  localparam int CLKS = 8;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   rx;
  logic                   cpu_hold;
  logic                   imem_we;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [INSTR_W-1:0]     imem_wdata;
  logic                   done;
  logic                   err;
  loader_state_e          dbg_state;
  rx_state_e              dbg_rx_state;

  int n_assert = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic [22:0] exp_q[$];

  imem_loader #(
    .CLKS_PER_BIT (CLKS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .cpu_hold     (cpu_hold),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state),
    .dbg_rx_state (dbg_rx_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [22:0] exp_word;
    if (imem_we) begin
      we_cnt++;
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL write_unexpected: observed addr=0x%0h data=0x%0h, expected no write",
               imem_addr, imem_wdata);
      end
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        n_assert++;
        assert ({imem_addr, imem_wdata} === exp_word) else begin
          n_fail++;
          $error("FAIL write_data: observed addr=0x%0h data=0x%0h, expected addr=0x%0h data=0x%0h",
                 imem_addr, imem_wdata, exp_word[22:15], exp_word[14:0]);
        end
      end
    end
    if (done) done_cnt++;
    if (imem_we && done) overlap_cnt++;
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_cycles(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CLKS);
    end
    rx = stop_bit;
    wait_cycles(CLKS);
    rx = 1'b1;
    wait_cycles(2 * CLKS);
  endtask

  task automatic push_word(input logic [7:0] addr, input logic [14:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int we0;
    int done0;
    logic [7:0] hb;
    logic [7:0] lb;
    logic [7:0] sum;

    rx    = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);

    // Reset values
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;
    wait_cycles(3 * CLKS);

    // Good frame: A5 02 01 01 00 05, checksum 05
    we0 = we_cnt; done0 = done_cnt;
    push_word(8'd0, 15'h0101);
    push_word(8'd1, 15'h0005);
    send_byte(8'hA5, 1'b1);
    check("a_hold_after_sync", 32'(cpu_hold), 32'd1);
    check("a_state_count", 32'(dbg_state), 32'(S_COUNT));
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    check("a_state_wlo", 32'(dbg_state), 32'(S_WLO));
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
`ifdef IMEM_LOADER_CSUM_EN
    check("a_done_before_csum", 32'(done_cnt - done0), 32'd0);
    check("a_state_csum", 32'(dbg_state), 32'(S_CSUM));
    check("a_hold_before_csum", 32'(cpu_hold), 32'd1);
`else
    check("a_done_after_last_write", 32'(done_cnt - done0), 32'd1);
    check("a_state_idle_after_last", 32'(dbg_state), 32'(S_IDLE));
`endif
    send_byte(8'h05, 1'b1);
    check("a_writes", 32'(we_cnt - we0), 32'd2);
    check("a_done_count", 32'(done_cnt - done0), 32'd1);
    check("a_err", 32'(err), 32'd0);
    check("a_hold_dropped", 32'(cpu_hold), 32'd0);
    check("a_exp_empty", 32'(exp_q.size()), 32'd0);

    // Same frame, checksum byte 00
    we0 = we_cnt; done0 = done_cnt;
    push_word(8'd0, 15'h0101);
    push_word(8'd1, 15'h0005);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    check("b_writes", 32'(we_cnt - we0), 32'd2);
`ifdef IMEM_LOADER_CSUM_EN
    check("b_err", 32'(err), 32'd1);
    check("b_done_count", 32'(done_cnt - done0), 32'd0);
`else
    check("b_err", 32'(err), 32'd0);
    check("b_done_count", 32'(done_cnt - done0), 32'd1);
`endif
    check("b_hold_dropped", 32'(cpu_hold), 32'd0);
    check("b_state_idle", 32'(dbg_state), 32'(S_IDLE));

    // Framing error on third byte
    we0 = we_cnt; done0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b0);
    check("c_err", 32'(err), 32'd1);
    check("c_no_write", 32'(we_cnt - we0), 32'd0);
    check("c_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("c_hold_dropped", 32'(cpu_hold), 32'd0);
    // Recovery with a good frame; sync byte clears err
    push_word(8'd0, 15'h0101);
    push_word(8'd1, 15'h0005);
    send_byte(8'hA5, 1'b1);
    check("c_err_cleared_by_sync", 32'(err), 32'd0);
    // Short glitch with the line idle mid-frame must not count as a byte
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(3 * CLKS);
    check("c_glitch_state_count", 32'(dbg_state), 32'(S_COUNT));
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h05, 1'b1);
    check("c_recover_writes", 32'(we_cnt - we0), 32'd2);
    check("c_recover_done", 32'(done_cnt - done0), 32'd1);
    check("c_recover_err", 32'(err), 32'd0);

    // Glitch while fully idle
    we0 = we_cnt; done0 = done_cnt;
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(3 * CLKS);
    check("d_glitch_rx_idle", 32'(dbg_rx_state), 32'(RX_IDLE));
    check("d_glitch_err", 32'(err), 32'd0);
    check("d_glitch_state", 32'(dbg_state), 32'(S_IDLE));
    check("d_glitch_no_write", 32'(we_cnt - we0), 32'd0);

    // High byte with bit 7 set
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1);
    check("e_err", 32'(err), 32'd1);
    check("e_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("e_hold_dropped", 32'(cpu_hold), 32'd0);
    check("e_no_write", 32'(we_cnt - we0), 32'd0);

    // N = 0: 256 words, addresses 0..255
    we0 = we_cnt; done0 = done_cnt;
    sum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      hb = 8'((i * 3) & 8'h7F);
      lb = 8'(i) ^ 8'h5A;
      sum = sum ^ hb ^ lb;
      push_word(8'(i), {hb[6:0], lb});
      send_byte(hb, 1'b1);
      send_byte(lb, 1'b1);
    end
    send_byte(sum, 1'b1);
    check("f_writes", 32'(we_cnt - we0), 32'd256);
    check("f_done_count", 32'(done_cnt - done0), 32'd1);
    check("f_err", 32'(err), 32'd0);
    check("f_hold_dropped", 32'(cpu_hold), 32'd0);
    check("f_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset after the first word of an N=4 frame
    we0 = we_cnt; done0 = done_cnt;
    push_word(8'd0, 15'h1234);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check("g_first_write", 32'(we_cnt - we0), 32'd1);
    check("g_hold_mid_frame", 32'(cpu_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    check("g_rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("g_rst_imem_we", 32'(imem_we), 32'd0);
    check("g_rst_imem_addr", 32'(imem_addr), 32'd0);
    check("g_rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("g_rst_done", 32'(done), 32'd0);
    check("g_rst_err", 32'(err), 32'd0);
    check("g_rst_state", 32'(dbg_state), 32'(S_IDLE));
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(CLKS);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h1A, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("g_no_more_writes", 32'(we_cnt - we0), 32'd1);
    check("g_no_done", 32'(done_cnt - done0), 32'd0);
    check("g_hold_low", 32'(cpu_hold), 32'd0);
    check("g_err_low", 32'(err), 32'd0);

    check("we_done_never_together", 32'(overlap_cnt), 32'd0);
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
